chip8_sprite_blitter: RTL and testbench
=======================================

Name: chip8_sprite_blitter

Overview:
Executes the CHIP-8/SCHIP DRW operation. It XORs an N-row, 8-pixel-wide sprite from memory into a byte-packed framebuffer held in the same memory, and reports pixel collision for VF. It sits beside the CPU on the shared byte-wide memory port and uses the CPU's request/ack read protocol. Screen geometry, framebuffer base and edge policy are parametrised, so one block serves 64x32 CHIP-8 and 128x64 SCHIP.

Parameters:
SCREEN_W, 64, screen width in pixels. Power of two, 16..256.
SCREEN_H, 32, screen height in pixels. Power of two, 8..256.
ADDR_W, 12, memory address width.
FB_BASE, 'h100, framebuffer base address. Row-major layout, SCREEN_W/8 bytes per row, MSB = leftmost pixel.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle draw request; sampled only in IDLE
pos_x  in  8  sprite X (VX value)
pos_y  in  8  sprite Y (VY value)
rows  in  4  sprite height N
spr_addr  in  ADDR_W  sprite source address (I)
wrap  in  1  1 = wrap at screen edges, 0 = clip
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at completion
collision  out  1  valid when done is high; holds until next accepted start
mem_read  out  1  read request
mem_read_idx  out  ADDR_W  read address
mem_read_byte  in  8  read data
mem_read_ack  in  1  read data valid (cycle after request)
mem_write  out  1  write strobe, committed at that clock edge
mem_write_idx  out  ADDR_W  write address
mem_write_byte  out  8  write data

Behaviour:
- Reset: state IDLE; busy=0, done=0, collision=0, mem_read=0, mem_write=0. Reset mid-draw aborts the draw with no further writes; bytes already written stay written.
- Start latches sx = pos_x mod SCREEN_W, sy = pos_y mod SCREEN_H, rows, spr_addr, wrap. It also clears collision and sets row counter r=0. start while busy is ignored.
- rows=0: go directly to DONE. No memory traffic; collision=0.
- Read protocol: mem_read and mem_read_idx are held while waiting. When ack=1 the data is captured and mem_read drops in that same cycle. Each read costs 2 cycles.
- States:
  - IDLE
  - LD_SPR: read spr_addr+r, wrapped at ADDR_W.
  - LD_L: read FB_BASE + ry*(SCREEN_W/8) + (sx>>3).
  - ST_L: write old ^ (spr >> (sx&7)).
  - LD_R: read the right neighbour byte.
  - ST_R: write old ^ (spr << (8-(sx&7))), 8-bit truncated.
  - DONE
- Row Y: ry = sy + r.
  - If ry >= SCREEN_H and wrap=1, use ry - SCREEN_H.
  - If ry >= SCREEN_H and wrap=0, go to DONE instead of LD_SPR.
- Right byte column = (sx>>3)+1.
  - If it equals SCREEN_W/8: wrap=1 uses column 0; wrap=0 skips LD_R/ST_R.
  - LD_R/ST_R are also skipped when (sx&7)==0.
- Collision: set if (old & shifted_sprite) != 0 on any stored byte. Sticky for the whole draw.
- Every visited byte is written, even when the sprite bits are zero.
- After ST_L (or ST_R): r += 1. Go to DONE if r == rows, else to LD_SPR.
- Cycle counts: 5 cycles per aligned row, 8 per unaligned row with the right byte visible; DONE adds 1. Example: aligned N=1 gives done 6 cycles after start.
- DONE: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- mem_read and mem_write are never asserted in the same cycle.

Test Plan:
1. W=64, H=32, mem[0x300]=0xF0, fb zero, start x=0 y=0 n=1 addr=0x300 -> mem[0x100]=0xF0, collision=0, done exactly 6 cycles after start.
2. Repeat test 1 without clearing the framebuffer -> mem[0x100]=0x00, collision=1.
3. x=3, sprite 0xFF -> mem[0x100]=0x1F, mem[0x101]=0xE0, done 9 cycles after start.
4. x=60, sprite 0xFF: wrap=1 -> mem[0x107]=0x0F, mem[0x100]=0xF0. wrap=0 -> mem[0x107]=0x0F, mem[0x100] untouched, 1 write only.
5. y=31, n=2, sprites 0x80 and 0x40: wrap=0 -> only mem[0x1F8]=0x80, mem[0x100]=0x00. wrap=1 -> also mem[0x100]=0x40. Second run with x=70 -> behaves as x=6.
6. start pulsed again while busy -> ignored, one done only. reset asserted in LD_R -> busy=0 next cycle, no ST_R write. W=128, H=64, x=8, y=1 -> write to 0x100+16+1=0x111.

Source files
------------

// File: rtl/chip8_sprite_blitter_if.sv
// ----------------------------------------------------------------------------
// chip8_sprite_blitter_if
// Shared byte-wide memory port used by the CHIP-8 CPU and the sprite blitter.
//   mem_read        : read request, held until mem_read_ack
//   mem_read_idx    : read address
//   mem_read_byte   : read data, valid together with mem_read_ack
//   mem_read_ack    : read data valid (cycle after the request)
//   mem_write       : write strobe, committed at the clock edge it is seen
//   mem_write_idx   : write address
//   mem_write_byte  : write data
// master = the requester (blitter), slave = the memory.
// ----------------------------------------------------------------------------
interface chip8_sprite_blitter_if #(
   parameter int ADDR_W = 12
);
   logic              mem_read;
   logic [ADDR_W-1:0] mem_read_idx;
   logic [7:0]        mem_read_byte;
   logic              mem_read_ack;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_write_idx;
   logic [7:0]        mem_write_byte;

   modport master (
      output mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
      input  mem_read_byte, mem_read_ack
   );

   modport slave (
      input  mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
      output mem_read_byte, mem_read_ack
   );
endinterface

// File: rtl/chip8_sprite_blitter.sv
// ----------------------------------------------------------------------------
// chip8_sprite_blitter
// Executes the CHIP-8/SCHIP DRW operation: XORs an N-row, 8-pixel-wide sprite
// into a byte-packed framebuffer held in the same memory and reports pixel
// collision (VF). Geometry, framebuffer base and edge policy (wrap/clip) are
// parameters/inputs so one block serves 64x32 and 128x64 screens.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start_i         : one-cycle draw request, sampled only when idle
//   pos_x_i/pos_y_i : sprite position (VX/VY), taken modulo the screen size
//   rows_i          : sprite height N (0 = no draw)
//   spr_addr_i      : sprite source address (I)
//   wrap_i          : 1 = wrap at screen edges, 0 = clip
//   busy_o          : draw in progress (through the done cycle)
//   done_o          : one-cycle completion pulse
//   collision_o     : any set pixel was cleared; held until the next start
//   mem             : shared memory port (master side)
// ----------------------------------------------------------------------------
module chip8_sprite_blitter #(
   parameter int SCREEN_W = 64,
   parameter int SCREEN_H = 32,
   parameter int ADDR_W   = 12,
   parameter int FB_BASE  = 'h100
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start_i,
   input  logic [7:0]                    pos_x_i,
   input  logic [7:0]                    pos_y_i,
   input  logic [3:0]                    rows_i,
   input  logic [ADDR_W-1:0]             spr_addr_i,
   input  logic                          wrap_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          collision_o,
   chip8_sprite_blitter_if.master        mem
);

   localparam int BPR = SCREEN_W / 8;        // framebuffer bytes per row
   localparam int XW  = $clog2(SCREEN_W);
   localparam int YW  = $clog2(SCREEN_H);
   localparam int CB  = XW - 3;              // byte-column index width

   typedef enum logic [2:0] {
      S_IDLE, S_LD_SPR, S_LD_L, S_ST_L, S_LD_R, S_ST_R, S_DONE
   } state_t;

   state_t            state_q;
   logic              busy_q, done_q, coll_q;
   logic              rd_q, wr_q;
   logic [ADDR_W-1:0] rd_idx_q, wr_idx_q;
   logic [7:0]        wr_byte_q;
   logic [XW-1:0]     sx_q;
   logic [YW-1:0]     sy_q, row_q;
   logic [3:0]        rows_q, r_q;
   logic [ADDR_W-1:0] spr_addr_q;
   logic              wrap_q;
   logic [7:0]        spr_q;

   logic [CB-1:0]     col_l, col_r;
   logic [15:0]       spr_sh;
   logic              skip_r;
   logic [3:0]        r_nx;
   logic [8:0]        ry_nx;
   logic              last_row, clip;

   function automatic logic [ADDR_W-1:0] fb_addr(input logic [YW-1:0] row,
                                                 input logic [CB-1:0] col);
      return ADDR_W'(FB_BASE) + (ADDR_W'(row) << CB) + ADDR_W'(col);
   endfunction

   // Sprite split across two bytes: [15:8] lands in the left byte, [7:0] in
   // the right neighbour (already the 8-bit truncated left shift by 8-(sx&7)).
   assign spr_sh   = {spr_q, 8'h00} >> sx_q[2:0];
   assign col_l    = sx_q[XW-1:3];
   assign col_r    = col_l + 1'b1;           // wraps to column 0 at the edge
   assign skip_r   = (sx_q[2:0] == 3'd0) || (!wrap_q && col_l == CB'(BPR - 1));
   assign r_nx     = r_q + 4'd1;
   assign ry_nx    = 9'(sy_q) + 9'(r_nx);
   assign last_row = (5'(r_q) + 5'd1) == 5'(rows_q);
   assign clip     = !wrap_q && (ry_nx >= 9'(SCREEN_H));

   // NOTE: the request is held until ack, but must not be seen by the memory
   // in the ack cycle or it would be taken as a second request.
   assign mem.mem_read       = rd_q & ~mem.mem_read_ack;
   assign mem.mem_read_idx   = rd_idx_q;
   assign mem.mem_write      = wr_q;
   assign mem.mem_write_idx  = wr_idx_q;
   assign mem.mem_write_byte = wr_byte_q;

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign collision_o = coll_q;

   // NOTE: sequential state uses non-blocking assignments only; datapath
   // registers (addresses, sprite, write data) are not reset because they are
   // always loaded before their strobe is raised.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         coll_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         wr_q <= 1'b0;                       // write strobe lasts one cycle
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  sx_q       <= XW'(pos_x_i);   // modulo SCREEN_W
                  sy_q       <= YW'(pos_y_i);   // modulo SCREEN_H
                  row_q      <= YW'(pos_y_i);
                  rows_q     <= rows_i;
                  spr_addr_q <= spr_addr_i;
                  wrap_q     <= wrap_i;
                  r_q        <= 4'd0;
                  coll_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  if (rows_i == 4'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= S_LD_SPR;
                     rd_q     <= 1'b1;
                     rd_idx_q <= spr_addr_i;
                  end
               end
            end

            S_LD_SPR: begin
               if (mem.mem_read_ack) begin
                  spr_q    <= mem.mem_read_byte;
                  state_q  <= S_LD_L;
                  rd_q     <= 1'b1;
                  rd_idx_q <= fb_addr(row_q, col_l);
               end
            end

            S_LD_L: begin
               if (mem.mem_read_ack) begin
                  rd_q      <= 1'b0;
                  wr_q      <= 1'b1;
                  wr_idx_q  <= rd_idx_q;
                  wr_byte_q <= mem.mem_read_byte ^ spr_sh[15:8];
                  coll_q    <= coll_q | (|(mem.mem_read_byte & spr_sh[15:8]));
                  state_q   <= S_ST_L;
               end
            end

            S_LD_R: begin
               if (mem.mem_read_ack) begin
                  rd_q      <= 1'b0;
                  wr_q      <= 1'b1;
                  wr_idx_q  <= rd_idx_q;
                  wr_byte_q <= mem.mem_read_byte ^ spr_sh[7:0];
                  coll_q    <= coll_q | (|(mem.mem_read_byte & spr_sh[7:0]));
                  state_q   <= S_ST_R;
               end
            end

            S_ST_L, S_ST_R: begin
               if (state_q == S_ST_L && !skip_r) begin
                  state_q  <= S_LD_R;
                  rd_q     <= 1'b1;
                  rd_idx_q <= fb_addr(row_q, col_r);
               end else begin
                  // Row finished: advance, wrapping the screen row mod H.
                  r_q   <= r_nx;
                  row_q <= ry_nx[YW-1:0];
                  if (last_row || clip) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= S_LD_SPR;
                     rd_q     <= 1'b1;
                     rd_idx_q <= spr_addr_q + ADDR_W'(r_nx);
                  end
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// ----------------------------------------------------------------------------
// tb_chip8_sprite_blitter
// Directed scoreboard bench: each draw pushes its expected result (collision,
// start-to-done latency, number of writes, framebuffer bytes) into a queue;
// a monitor pops and compares whenever a done pulse appears.
// DUT a: 64x32, DUT b: 128x64, both FB_BASE 0x100, ADDR_W 12.
// ----------------------------------------------------------------------------
module tb_chip8_sprite_blitter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   logic        start_a, start_b;
   logic [7:0]  px, py;
   logic [3:0]  nrows;
   logic [11:0] saddr;
   logic        wrap;
   logic        busy_a, done_a, coll_a, busy_b, done_b, coll_b;

   chip8_sprite_blitter_if #(.ADDR_W(12)) bus_a ();
   chip8_sprite_blitter_if #(.ADDR_W(12)) bus_b ();

   chip8_sprite_blitter #(.SCREEN_W(64), .SCREEN_H(32), .ADDR_W(12), .FB_BASE('h100)) u_dut_a (
      .clk(clk), .reset(reset), .start_i(start_a), .pos_x_i(px), .pos_y_i(py),
      .rows_i(nrows), .spr_addr_i(saddr), .wrap_i(wrap), .busy_o(busy_a),
      .done_o(done_a), .collision_o(coll_a), .mem(bus_a));

   chip8_sprite_blitter #(.SCREEN_W(128), .SCREEN_H(64), .ADDR_W(12), .FB_BASE('h100)) u_dut_b (
      .clk(clk), .reset(reset), .start_i(start_b), .pos_x_i(px), .pos_y_i(py),
      .rows_i(nrows), .spr_addr_i(saddr), .wrap_i(wrap), .busy_o(busy_b),
      .done_o(done_b), .collision_o(coll_b), .mem(bus_b));

   // Memory models: ack and data one cycle after a request, writes committed
   // at the edge the strobe is seen.
   logic [7:0] mem_a [4096];
   logic [7:0] mem_b [4096];
   int wr_a = 0;
   int wr_b = 0;

   always @(posedge clk) begin
      bus_a.mem_read_ack <= bus_a.mem_read;
      if (bus_a.mem_read) bus_a.mem_read_byte <= mem_a[bus_a.mem_read_idx];
      if (bus_a.mem_write) begin
         mem_a[bus_a.mem_write_idx] = bus_a.mem_write_byte;
         wr_a++;
      end
      bus_b.mem_read_ack <= bus_b.mem_read;
      if (bus_b.mem_read) bus_b.mem_read_byte <= mem_b[bus_b.mem_read_idx];
      if (bus_b.mem_write) begin
         mem_b[bus_b.mem_write_idx] = bus_b.mem_write_byte;
         wr_b++;
      end
   end

   typedef struct {
      string name;
      int    start_cyc;
      int    lat;
      int    wr0;
      int    nwr;
      bit    coll;
      int    n;
      int    a0, v0, a1, v1;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic score(input exp_t e, input bit sel);
      int wr;
      int c;
      wr = sel ? wr_b : wr_a;
      c  = sel ? int'(coll_b) : int'(coll_a);
      check({e.name, ".collision"}, c, int'(e.coll));
      check({e.name, ".latency"}, cyc - e.start_cyc, e.lat);
      check({e.name, ".writes"}, wr - e.wr0, e.nwr);
      if (e.n > 0) check({e.name, ".byte0"}, sel ? int'(mem_b[e.a0]) : int'(mem_a[e.a0]), e.v0);
      if (e.n > 1) check({e.name, ".byte1"}, sel ? int'(mem_b[e.a1]) : int'(mem_a[e.a1]), e.v1);
   endtask

   // Monitors: sample away from the active edge.
   always @(negedge clk) begin
      if (!reset && done_a) begin
         if (q_a.size() == 0) check("a.unexpected_done", 1, 0);
         else score(q_a.pop_front(), 1'b0);
      end
      if (!reset && done_b) begin
         if (q_b.size() == 0) check("b.unexpected_done", 1, 0);
         else score(q_b.pop_front(), 1'b1);
      end
      if (bus_a.mem_read && bus_a.mem_write) check("a.read_write_overlap", 1, 0);
      if (bus_b.mem_read && bus_b.mem_write) check("b.read_write_overlap", 1, 0);
   end

   task automatic wait_idle(input bit sel, input string nm);
      int t;
      t = 0;
      while ((sel ? q_b.size() : q_a.size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         check({nm, ".timeout"}, 1, 0);
         if (sel) q_b.delete(); else q_a.delete();
      end
      @(negedge clk);
   endtask

   task automatic issue(input bit sel, input string nm, input int x, input int y,
                        input int n, input bit w, input int lat, input int nwr,
                        input bit coll, input int nchk, input int a0, input int v0,
                        input int a1, input int v1);
      exp_t e;
      @(negedge clk);
      px = 8'(x); py = 8'(y); nrows = 4'(n); saddr = 12'h300; wrap = w;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      e.name = nm; e.start_cyc = cyc; e.lat = lat; e.nwr = nwr; e.coll = coll;
      e.n = nchk; e.a0 = a0; e.v0 = v0; e.a1 = a1; e.v1 = v1;
      e.wr0 = sel ? wr_b : wr_a;
      if (sel) q_b.push_back(e); else q_a.push_back(e);
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic draw(input bit sel, input string nm, input int x, input int y,
                       input int n, input bit w, input int lat, input int nwr,
                       input bit coll, input int nchk, input int a0, input int v0,
                       input int a1, input int v1);
      issue(sel, nm, x, y, n, w, lat, nwr, coll, nchk, a0, v0, a1, v1);
      wait_idle(sel, nm);
   endtask

   task automatic clear_fb();
      for (int i = 'h100; i < 'h200; i++) mem_a[i] = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, w0;
      for (int i = 0; i < 4096; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      px = '0; py = '0; nrows = '0; saddr = '0; wrap = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.busy", int'(busy_a), 0);
      check("reset.done", int'(done_a), 0);
      check("reset.collision", int'(coll_a), 0);
      check("reset.mem_read", int'(bus_a.mem_read), 0);
      check("reset.mem_write", int'(bus_a.mem_write), 0);
      reset = 1'b0;
      @(negedge clk);

      // 1/2: aligned draw, then erase with collision
      mem_a['h300] = 8'hF0;
      draw(0, "t1", 0, 0, 1, 0, 6, 1, 0, 1, 'h100, 'hF0, 0, 0);
      draw(0, "t2", 0, 0, 1, 0, 6, 1, 1, 1, 'h100, 'h00, 0, 0);
      repeat (3) @(negedge clk);
      check("t2.collision_hold", int'(coll_a), 1);
      // rows=0: immediate done, collision cleared, no traffic
      draw(0, "rows0", 5, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      // 3: unaligned, both bytes
      clear_fb(); mem_a['h300] = 8'hFF;
      draw(0, "t3", 3, 0, 1, 0, 9, 2, 0, 2, 'h100, 'h1F, 'h101, 'hE0);

      // 4: right edge wrap / clip
      clear_fb();
      draw(0, "t4wrap", 60, 0, 1, 1, 9, 2, 0, 2, 'h107, 'h0F, 'h100, 'hF0);
      clear_fb();
      draw(0, "t4clip", 60, 0, 1, 0, 6, 1, 0, 2, 'h107, 'h0F, 'h100, 'h00);

      // 5: bottom edge clip / wrap, then x modulo width
      clear_fb(); mem_a['h300] = 8'h80; mem_a['h301] = 8'h40;
      draw(0, "t5clip", 0, 31, 2, 0, 6, 1, 0, 2, 'h1F8, 'h80, 'h100, 'h00);
      clear_fb();
      draw(0, "t5wrap", 0, 31, 2, 1, 11, 2, 0, 2, 'h1F8, 'h80, 'h100, 'h40);
      clear_fb(); mem_a['h300] = 8'hFF;
      draw(0, "t5xmod", 70, 0, 1, 0, 9, 2, 0, 2, 'h100, 'h03, 'h101, 'hFC);

      // 6a: start while busy is ignored
      clear_fb(); mem_a['h300] = 8'hF0;
      issue(0, "t6busy", 0, 0, 1, 0, 6, 1, 0, 2, 'h100, 'hF0, 'h101, 'h00);
      @(negedge clk);
      px = 8'd8; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_idle(0, "t6busy");
      repeat (20) @(negedge clk);

      // 6b: reset while waiting on the right-byte read
      clear_fb(); mem_a['h300] = 8'hFF;
      @(negedge clk);
      px = 8'd3; py = 8'd0; nrows = 4'd1; saddr = 12'h300; wrap = 1'b0;
      start_a = 1'b1; c0 = cyc; w0 = wr_a;
      @(negedge clk);
      start_a = 1'b0;
      while (cyc < c0 + 6) @(negedge clk);
      check("t6rst.ld_r_read", int'(bus_a.mem_read), 1);
      check("t6rst.ld_r_idx", int'(bus_a.mem_read_idx), 'h101);
      reset = 1'b1;
      @(negedge clk);
      check("t6rst.busy", int'(busy_a), 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("t6rst.writes", wr_a - w0, 1);
      check("t6rst.left", int'(mem_a['h100]), 'h1F);
      check("t6rst.right", int'(mem_a['h101]), 'h00);

      // 6c: 128x64 geometry
      mem_b['h300] = 8'hA5;
      draw(1, "t6big", 8, 1, 1, 0, 6, 1, 0, 1, 'h111, 'hA5, 0, 0);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
